// File: rtl/mtr_drv_multi.sv
// mtr_drv_multi: multi-phase motor gate drive.
//   One shared edge-aligned PWM generator (period 2^PWM_W clocks, double-buffered duty)
//   feeds NUM_PH commutation muxes, each followed by a programmable dead-time
//   nonoverlap stage driving the high/low gate enables.
// Optional feature: define MTR_DRV_FAULT_EN to add the fault input and the latched
//   fault_flag output (fault forces all gates off until a period end with fault low).
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   duty       requested duty, loaded into the shadow register at period end
//   sel        per-phase mode, phase p uses sel[2p+1:2p] (00 coast, 01 rev, 10 fwd, 11 brake)
//   dead_time  dead-time setting, sampled when a dead-time interval starts
//   PWM_synch  one-cycle pulse when the PWM output reflects counter value 0
//   high/low   per-phase high-side / low-side gate enables
//   fault      fault request (MTR_DRV_FAULT_EN only)
//   fault_flag latched fault status (MTR_DRV_FAULT_EN only)
module mtr_drv_multi #(
    parameter int unsigned NUM_PH = 3,
    parameter int unsigned PWM_W  = 11,
    parameter int unsigned DEAD_W = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [PWM_W-1:0]      duty,
    input  logic [2*NUM_PH-1:0]   sel,
    input  logic [DEAD_W-1:0]     dead_time,
    output logic                  PWM_synch,
    output logic [NUM_PH-1:0]     high,
    output logic [NUM_PH-1:0]     low
`ifdef MTR_DRV_FAULT_EN
    ,
    input  logic                  fault,
    output logic                  fault_flag
`endif
);

    localparam logic [PWM_W-1:0] CntMax = '1;

    logic [PWM_W-1:0] cnt;
    logic [PWM_W-1:0] duty_shdw;
    logic             pwm_sig;
    logic             wrapped;
    logic             period_end;
    logic             fault_hold;

    assign period_end = (cnt == CntMax);

    // Shared PWM generator. The counter sits at 0 during reset, which is not a real
    // period start: PWM_synch is only issued once the counter has wrapped at least once.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt       <= '0;
            duty_shdw <= '0;
            pwm_sig   <= 1'b0;
            PWM_synch <= 1'b0;
            wrapped   <= 1'b0;
        end else begin
            cnt       <= cnt + PWM_W'(1);
            pwm_sig   <= (cnt < duty_shdw);
            PWM_synch <= wrapped && (cnt == '0);
            if (period_end) begin
                duty_shdw <= duty;
                wrapped   <= 1'b1;
            end
        end
    end

`ifdef MTR_DRV_FAULT_EN
    // Flag sets on any sampled fault and clears only at a period end with fault low.
    always_ff @(posedge clk) begin
        if (rst) begin
            fault_flag <= 1'b0;
        end else if (fault) begin
            fault_flag <= 1'b1;
        end else if (period_end) begin
            fault_flag <= 1'b0;
        end
    end

    // Also true on the clearing edge, so every phase reloads its dead-time counter there.
    assign fault_hold = fault | fault_flag;
`else
    assign fault_hold = 1'b0;
`endif

    for (genvar p = 0; p < NUM_PH; p++) begin : g_ph
        logic [1:0]        ph_sel;
        logic              h_in;
        logic              l_in;
        logic              hq;
        logic              lq;
        logic              h_out;
        logic              l_out;
        logic [DEAD_W-1:0] dcnt;

        assign ph_sel = sel[2*p +: 2];

        always_comb begin
            h_in = 1'b0;
            l_in = 1'b0;
            unique case (ph_sel)
                2'b00: begin
                    h_in = 1'b0;
                    l_in = 1'b0;
                end
                2'b01: begin
                    h_in = ~pwm_sig;
                    l_in = pwm_sig;
                end
                2'b10: begin
                    h_in = pwm_sig;
                    l_in = ~pwm_sig;
                end
                2'b11: begin
                    h_in = 1'b0;
                    l_in = pwm_sig;
                end
            endcase
        end

        // Any change of the requested levels blanks both gates for dead_time+1 cycles;
        // hq/lq never both 1 (mux table), so the outputs can never overlap.
        always_ff @(posedge clk) begin
            if (rst) begin
                hq    <= 1'b0;
                lq    <= 1'b0;
                dcnt  <= '0;
                h_out <= 1'b0;
                l_out <= 1'b0;
            end else if (fault_hold) begin
                hq    <= h_in;
                lq    <= l_in;
                dcnt  <= dead_time;
                h_out <= 1'b0;
                l_out <= 1'b0;
            end else if ((h_in != hq) || (l_in != lq)) begin
                hq    <= h_in;
                lq    <= l_in;
                dcnt  <= dead_time;
                h_out <= 1'b0;
                l_out <= 1'b0;
            end else if (dcnt != '0) begin
                dcnt  <= dcnt - DEAD_W'(1);
                h_out <= 1'b0;
                l_out <= 1'b0;
            end else begin
                h_out <= hq;
                l_out <= lq;
            end
        end

        assign high[p] = h_out;
        assign low[p]  = l_out;
    end

endmodule

// File: tb/tb_mtr_drv_multi.sv
// Directed bench for mtr_drv_multi: a 3-phase 11-bit instance and a 6-phase 8-bit instance.
module tb_mtr_drv_multi;

    logic        clk = 1'b0;
    logic        rst;
    logic [10:0] duty;
    logic [5:0]  sel;
    logic [4:0]  dead_time;
    logic        synch;
    logic [2:0]  high;
    logic [2:0]  low;

    logic [7:0]  duty6;
    logic [11:0] sel6;
    logic [4:0]  dead6;
    logic        synch6;
    logic [5:0]  high6;
    logic [5:0]  low6;

`ifdef MTR_DRV_FAULT_EN
    logic fault = 1'b0;
    logic fault_flag;
    logic fault6 = 1'b0;
    logic fault_flag6;
`endif

    int checks = 0;
    int failures = 0;
    int overlap_err = 0;
    int hc[3];
    int lc[3];

    always #5 clk = ~clk;

    mtr_drv_multi #(.NUM_PH(3), .PWM_W(11), .DEAD_W(5)) dut (
        .clk       (clk),
        .rst       (rst),
        .duty      (duty),
        .sel       (sel),
        .dead_time (dead_time),
        .PWM_synch (synch),
        .high      (high),
        .low       (low)
`ifdef MTR_DRV_FAULT_EN
        ,
        .fault     (fault),
        .fault_flag(fault_flag)
`endif
    );

    mtr_drv_multi #(.NUM_PH(6), .PWM_W(8), .DEAD_W(5)) dut6 (
        .clk       (clk),
        .rst       (rst),
        .duty      (duty6),
        .sel       (sel6),
        .dead_time (dead6),
        .PWM_synch (synch6),
        .high      (high6),
        .low       (low6)
`ifdef MTR_DRV_FAULT_EN
        ,
        .fault     (fault6),
        .fault_flag(fault_flag6)
`endif
    );

    always @(negedge clk) begin
        if (((high & low) != 3'b0) || ((high6 & low6) != 6'b0)) overlap_err++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One full period of the 3-phase instance, starting at a PWM_synch sample point.
    task automatic run_window(input int set_at, input logic [10:0] set_val,
                              output int pwm_hi, output int syn_n, output int syn_pos);
        pwm_hi = 0;
        syn_n = 0;
        syn_pos = -1;
        for (int p = 0; p < 3; p++) begin
            hc[p] = 0;
            lc[p] = 0;
        end
        for (int i = 0; i < 2048; i++) begin
            if (dut.pwm_sig === 1'b1) pwm_hi++;
            if (synch === 1'b1) begin
                syn_n++;
                syn_pos = i;
            end
            for (int p = 0; p < 3; p++) begin
                if (high[p] === 1'b1) hc[p]++;
                if (low[p] === 1'b1) lc[p]++;
            end
            if (i == set_at) duty = set_val;
            tick();
        end
    endtask

    task automatic align(output logic ok);
        ok = 1'b0;
        for (int i = 0; i < 2100; i++) begin
            if (synch === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    task automatic test_reset;
        int n;
        rst = 1'b1;
        sel = 6'b101010;
        duty = 11'd512;
        dead_time = 5'd4;
        duty6 = 8'd0;
        sel6 = 12'b0;
        dead6 = 5'd0;
        repeat (3) tick();
        checks++;
        if (high !== 3'b0 || low !== 3'b0) begin
            failures++;
            $display("FAIL reset_gates: high=%b low=%b want 000/000", high, low);
        end
        checks++;
        if (synch !== 1'b0) begin
            failures++;
            $display("FAIL reset_synch: got %b want 0", synch);
        end
        checks++;
        if (high6 !== 6'b0 || low6 !== 6'b0 || synch6 !== 1'b0) begin
            failures++;
            $display("FAIL reset_dut6: high=%b low=%b synch=%b want zeros", high6, low6, synch6);
        end
        rst = 1'b0;
        n = 0;
        for (int i = 0; i < 3000; i++) begin
            tick();
            n++;
            if (synch === 1'b1) break;
        end
        checks++;
        if (n != 2049) begin
            failures++;
            $display("FAIL first_synch: got %0d cycles want 2049", n);
        end
    endtask

    task automatic test_duty_shadow;
        int set_at[4];
        int set_val[4];
        int exp_hi[4];
        int exp_h[4];
        int exp_l[4];
        int pwm_hi, syn_n, syn_pos;
        set_at  = '{100, 100, 2046, 100};
        set_val = '{1024, 0, 100, 0};
        exp_hi  = '{512, 1024, 0, 100};
        exp_h   = '{507, 1019, 0, 95};
        exp_l   = '{1531, 1019, 2048, 1943};
        for (int w = 0; w < 4; w++) begin
            run_window(set_at[w], set_val[w][10:0], pwm_hi, syn_n, syn_pos);
            checks++;
            if (pwm_hi != exp_hi[w]) begin
                failures++;
                $display("FAIL duty_window%0d: pwm high %0d want %0d", w, pwm_hi, exp_hi[w]);
            end
            checks++;
            if (syn_n != 1 || syn_pos != 0) begin
                failures++;
                $display("FAIL synch_window%0d: count %0d pos %0d want 1 at 0", w, syn_n, syn_pos);
            end
            checks++;
            if (hc[2] != exp_h[w] || lc[2] != exp_l[w]) begin
                failures++;
                $display("FAIL fwd_gates_window%0d: high %0d low %0d want %0d %0d",
                         w, hc[2], lc[2], exp_h[w], exp_l[w]);
            end
        end
    endtask

    task automatic test_dead_restart;
        logic [1:0] want;
        checks++;
        if (high[0] !== 1'b0 || low[0] !== 1'b1) begin
            failures++;
            $display("FAIL restart_pre: h=%b l=%b want 0 1", high[0], low[0]);
        end
        dead_time = 5'd8;
        sel[1:0] = 2'b01;
        for (int k = 0; k <= 12; k++) begin
            tick();
            want = (k == 12) ? 2'b01 : 2'b00;
            checks++;
            if ({high[0], low[0]} !== want) begin
                failures++;
                $display("FAIL restart_edge%0d: hl=%b want %b", k, {high[0], low[0]}, want);
            end
            if (k == 2) sel[1:0] = 2'b10;
        end
        dead_time = 5'd4;
    endtask

`ifdef MTR_DRV_FAULT_EN
    task automatic test_fault;
        logic ok;
        int k, m, bad;
        sel[1:0] = 2'b01;
        align(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL fault_align: no PWM_synch got %b want 1", ok);
        end
        repeat (99) tick();
        checks++;
        if (high[0] !== 1'b1) begin
            failures++;
            $display("FAIL fault_pre: high0=%b want 1", high[0]);
        end
        fault = 1'b1;
        tick();
        fault = 1'b0;
        checks++;
        if (high !== 3'b0 || low !== 3'b0 || fault_flag !== 1'b1) begin
            failures++;
            $display("FAIL fault_hit: high=%b low=%b flag=%b want 000 000 1", high, low, fault_flag);
        end
        k = 0;
        bad = 0;
        while (fault_flag === 1'b1 && k < 3000) begin
            tick();
            k++;
            if (high !== 3'b0 || low !== 3'b0) bad++;
        end
        checks++;
        if (k != 1947 || bad != 0) begin
            failures++;
            $display("FAIL fault_clear: cycles %0d active %0d want 1947 0", k, bad);
        end
        m = 0;
        while (high[0] !== 1'b1 && m < 100) begin
            tick();
            m++;
        end
        checks++;
        if (m != 5) begin
            failures++;
            $display("FAIL fault_resume: cycles %0d want 5", m);
        end
    endtask
`endif

    task automatic test_modes;
        logic ok;
        int pwm_hi, syn_n, syn_pos;
        int eh[2][3];
        int el[2][3];
        logic [5:0] sels[2];
        eh = '{'{0, 1787, 251}, '{1787, 251, 0}};
        el = '{'{0, 251, 1787}, '{251, 1787, 251}};
        sels = '{6'b10_01_00, 6'b11_10_01};
        align(ok);
        checks++;
        if (ok !== 1'b1) begin
            failures++;
            $display("FAIL modes_align: no PWM_synch got %b want 1", ok);
        end
        dead_time = 5'd4;
        duty = 11'd256;
        for (int r = 0; r < 2; r++) begin
            sel = sels[r];
            run_window(-1, 11'd0, pwm_hi, syn_n, syn_pos);
            run_window(-1, 11'd0, pwm_hi, syn_n, syn_pos);
            checks++;
            if (pwm_hi != 256) begin
                failures++;
                $display("FAIL modes_pwm%0d: high %0d want 256", r, pwm_hi);
            end
            for (int p = 0; p < 3; p++) begin
                checks++;
                if (hc[p] != eh[r][p] || lc[p] != el[r][p]) begin
                    failures++;
                    $display("FAIL modes_run%0d_ph%0d: high %0d low %0d want %0d %0d",
                             r, p, hc[p], lc[p], eh[r][p], el[r][p]);
                end
            end
        end
    endtask

    task automatic test_reset_mid;
        repeat (300) tick();
        checks++;
        if (high[0] !== 1'b1) begin
            failures++;
            $display("FAIL midreset_pre: high0=%b want 1", high[0]);
        end
        rst = 1'b1;
        sel = 6'b000110;
        tick();
        checks++;
        if (high !== 3'b0 || low !== 3'b0 || synch !== 1'b0 || dut.pwm_sig !== 1'b0) begin
            failures++;
            $display("FAIL midreset: high=%b low=%b synch=%b pwm=%b want zeros",
                     high, low, synch, dut.pwm_sig);
        end
        rst = 1'b0;
    endtask

    task automatic test_params;
        int found, syn_n, syn_pos;
        int h6[6];
        int l6[6];
        int eh6[6];
        int el6[6];
        eh6 = '{191, 63, 0, 0, 191, 63};
        el6 = '{63, 191, 0, 63, 63, 191};
        sel6 = 12'b10_01_11_00_10_01;
        duty6 = 8'd64;
        dead6 = 5'd0;
        found = 0;
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 300; i++) begin
                if (synch6 === 1'b1) begin
                    found++;
                    break;
                end
                tick();
            end
            if (r < 2) tick();
        end
        checks++;
        if (found != 3) begin
            failures++;
            $display("FAIL params_align: synch seen %0d want 3", found);
        end
        syn_n = 0;
        syn_pos = -1;
        for (int p = 0; p < 6; p++) begin
            h6[p] = 0;
            l6[p] = 0;
        end
        for (int i = 0; i < 256; i++) begin
            if (synch6 === 1'b1) begin
                syn_n++;
                syn_pos = i;
            end
            for (int p = 0; p < 6; p++) begin
                if (high6[p] === 1'b1) h6[p]++;
                if (low6[p] === 1'b1) l6[p]++;
            end
            tick();
        end
        checks++;
        if (syn_n != 1 || syn_pos != 0) begin
            failures++;
            $display("FAIL params_period: synch count %0d pos %0d want 1 at 0", syn_n, syn_pos);
        end
        for (int p = 0; p < 6; p++) begin
            checks++;
            if (h6[p] != eh6[p] || l6[p] != el6[p]) begin
                failures++;
                $display("FAIL params_ph%0d: high %0d low %0d want %0d %0d",
                         p, h6[p], l6[p], eh6[p], el6[p]);
            end
        end
    endtask

    task automatic test_overlap;
        checks++;
        if (overlap_err != 0) begin
            failures++;
            $display("FAIL overlap: %0d cycles with high&low want 0", overlap_err);
        end
    endtask

    initial begin
        test_reset();
        test_duty_shadow();
        test_dead_restart();
`ifdef MTR_DRV_FAULT_EN
        test_fault();
`endif
        test_modes();
        test_reset_mid();
        test_params();
        test_overlap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mtr_drv_multi.md
# mtr_drv_multi

Parametrised successor to the 3-phase motor drive block: one shared edge-aligned PWM generator plus NUM_PH per-phase commutation muxes and dead-time nonoverlap stages. It adds double-buffered duty, a programmable dead-time counter per phase, and an optional latched fault shutdown. It sits between the commutation/brushless controller and the gate-driver pads.

## Interface
Parameters:
- NUM_PH, 3, number of motor phases (≥1)
- PWM_W, 11, PWM counter/duty width; period = 2^PWM_W clocks
- DEAD_W, 5, dead-time counter width

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  reset, synchronous, active-high
- duty  in  PWM_W  requested duty; sampled into shadow only at period end
- sel  in  2*NUM_PH  per-phase select; phase p uses sel[2p+1:2p]
- dead_time  in  DEAD_W  dead-time setting D, sampled when a dead-time interval starts
- PWM_synch  out  1  one-cycle pulse at start of each PWM period
- high  out  NUM_PH  high-side gate enables
- low  out  NUM_PH  low-side gate enables
- fault  in  1  overcurrent/fault request (only with FAULT_EN)
- fault_flag  out  1  latched fault status (only with FAULT_EN)

## Operation
- PWM counter cnt (PWM_W bits) free-runs 0 .. 2^PWM_W-1, wraps to 0.
- duty_shdw <= duty on the edge where cnt == 2^PWM_W-1; never mid-period.
- PWM_sig (registered) <= (cnt < duty_shdw). duty 0 → always low; all-ones → high 2^PWM_W-1 of 2^PWM_W cycles.
- PWM_synch (registered) high for exactly the cycle in which PWM_sig reflects cnt == 0.
- Per-phase mux (comb from PWM_sig, sel pair) → hIn/lIn:
  - 00 coast: hIn=0, lIn=0
  - 01 reverse: hIn=~PWM_sig, lIn=PWM_sig
  - 10 forward: hIn=PWM_sig, lIn=~PWM_sig
  - 11 brake: hIn=0, lIn=PWM_sig
- Per-phase nonoverlap, registers hq/lq (last sampled hIn/lIn) and dcnt (DEAD_W):
  - Change (hIn≠hq or lIn≠lq): high[p],low[p] <= 0; dcnt <= dead_time; hq/lq updated.
  - Else if dcnt ≠ 0: dcnt decrements; outputs stay 0.
  - Else: high[p] <= hq, low[p] <= lq.
  - A change during an active interval restarts it with current dead_time.
  - high[p] and low[p] are never both 1 in any cycle.
- Phases are independent; sel may change any cycle (handled as an input change).

## Timing
- Reset values: cnt 0, duty_shdw 0, PWM_sig 0, PWM_synch 0, hq/lq 0, dcnt 0, high/low all 0, fault_flag 0.
- Reset asserted mid-operation: all above values on the next edge; outputs low regardless of dead-time state.
- First PWM_synch: cycle after first cnt == 0 following reset release.
- Input change at edge n with setting D: outputs 0 for edges n .. n+D, new levels appear after edge n+D+1 (D+1 low cycles; D=0 gives 1-cycle gap).
- PWM_sig lags cnt by 1 cycle; gate outputs lag PWM_sig by ≥ D+2 cycles on every transition.
- Duty written at cnt==2^PWM_W-1 edge takes effect in the immediately following period.

## Configuration
- MTR_DRV_FAULT_EN defined: fault and fault_flag ports exist. fault sampled high → fault_flag <= 1 and all high/low <= 0 on the same edge, overriding dead-time logic. fault_flag clears only on the period-end edge (cnt == 2^PWM_W-1) with fault low; dcnt reloads so outputs resume after a full dead-time interval. PWM counter and PWM_synch keep running during fault.
- Undefined: ports absent, no latch; behaviour as above.

## Test plan
- Reset: drive rst 1 for 3 cycles with sel=all 10, duty=512 → all outputs 0, PWM_synch 0; PWM_synch first pulse 2048+1 cycles after release (PWM_W=11).
- Duty shadow: duty=512 then 1024 written mid-period → current period high 512 cycles, next 1024; duty=0 → PWM_sig never high.
- Modes: NUM_PH=3, sel per phase 00/01/10/11, duty=256, D=4 → high/low match mux table, each edge preceded by 5 low cycles, no high&low overlap ever.
- Dead-time restart: D=8, toggle sel at edge n and again at n+3 → outputs stay 0 until n+3+9.
- Parameters: NUM_PH=6, PWM_W=8, D=0 → period 256, 1-cycle gaps, six phases independent.
- Fault (FAULT_EN): fault pulse at cnt=100 → outputs 0 next edge, fault_flag 1 until period-end with fault low, outputs resume D+1 cycles later.
